// File: rtl/pixel2byte_packer.sv
// Packs RAW8/RAW10/RAW12 pixels into the CSI-2 byte stream for the pixel-to-byte FIFO
// and reports each line's byte count as the CSI-2 word count.
module pixel2byte_packer #(
    parameter int PIX_BITS = 10,
    parameter int WC_WIDTH = 16
) (
    input  logic                WrClock,
    input  logic                Reset,
    input  logic [PIX_BITS-1:0] pix_data,
    input  logic                pix_valid,
    input  logic                pix_last,
    output logic                pix_ready,
    output logic [7:0]          fifo_Data,
    output logic                fifo_WrEn,
    input  logic                fifo_AlmostFull,
    input  logic                fifo_Full,
    output logic [WC_WIDTH-1:0] line_wc,
    output logic                line_wc_valid,
    output logic                err_partial,
    output logic                err_overflow
);

    generate
        if (PIX_BITS != 8 && PIX_BITS != 10 && PIX_BITS != 12) begin : g_bad_pix_bits
            $error("pixel2byte_packer: PIX_BITS must be 8, 10 or 12");
        end
    endgenerate

    typedef enum logic {
        COLLECT  = 1'b0,
        EMIT_LSB = 1'b1
    } state_t;

    // Index of the last pixel in an LSB-sharing group (4 pixels for RAW10, 2 for RAW12).
    localparam logic [1:0]          GROUP_LAST = (PIX_BITS == 12) ? 2'd1 : 2'd3;
    localparam logic [WC_WIDTH-1:0] WC_ONE     = {{(WC_WIDTH-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [1:0]          k_q, k_d;
    logic [7:0]          lsb_q, lsb_d;
    logic                last_q, last_d;
    logic [7:0]          data_q, data_d;
    logic                wr_q, wr_d;
    logic [WC_WIDTH-1:0] count_q, count_d;
    logic [WC_WIDTH-1:0] wc_q, wc_d;
    logic                wcv_q, wcv_d;
    logic                partial_q, partial_d;
    logic                overflow_q, overflow_d;

    logic                accept_s;
    logic                final_s;
    logic [7:0]          msb_s;
    logic [3:0]          lsb_nib_s;
    logic [2:0]          lsb_shift_s;

    assign pix_ready     = (state_q == COLLECT) && !fifo_AlmostFull;
    assign accept_s      = pix_valid && pix_ready;
    assign msb_s         = pix_data[PIX_BITS-1 -: 8];

    assign fifo_Data     = data_q;
    assign fifo_WrEn     = wr_q;
    assign line_wc       = wc_q;
    assign line_wc_valid = wcv_q;
    assign err_partial   = partial_q;
    assign err_overflow  = overflow_q;

    // Low-order pixel bits and their bit position inside the shared LSB byte.
    always_comb begin
        if (PIX_BITS == 10) begin
            lsb_nib_s   = {2'b00, pix_data[1:0]};
            lsb_shift_s = {k_q, 1'b0};
        end else if (PIX_BITS == 12) begin
            lsb_nib_s   = pix_data[3:0];
            lsb_shift_s = {k_q[0], 2'b00};
        end else begin
            lsb_nib_s   = 4'h0;
            lsb_shift_s = 3'd0;
        end
    end

    // Next-state logic: pixel accept, LSB emission, line byte counting and error flags.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        lsb_d      = lsb_q;
        last_d     = last_q;
        data_d     = data_q;
        wr_d       = 1'b0;
        count_d    = count_q;
        wc_d       = wc_q;
        wcv_d      = 1'b0;
        partial_d  = partial_q;
        overflow_d = overflow_q | (wr_q & fifo_Full);
        final_s    = 1'b0;

        case (state_q)
            COLLECT: begin
                if (accept_s) begin
                    data_d = msb_s;
                    wr_d   = 1'b1;
                    if (PIX_BITS == 8) begin
                        final_s = pix_last;
                    end else begin
                        lsb_d = lsb_q | ({4'h0, lsb_nib_s} << lsb_shift_s);
                        if ((k_q == GROUP_LAST) || pix_last) begin
                            state_d   = EMIT_LSB;
                            last_d    = pix_last;
                            partial_d = partial_q | (k_q != GROUP_LAST);
                        end else begin
                            k_d = k_q + 2'd1;
                        end
                    end
                end else begin
                    wr_d = 1'b0;
                end
            end
            EMIT_LSB: begin
                // Committed regardless of AlmostFull; the FIFO threshold reserves room for it.
                data_d  = lsb_q;
                wr_d    = 1'b1;
                final_s = last_q;
                lsb_d   = 8'h00;
                k_d     = 2'd0;
                last_d  = 1'b0;
                state_d = COLLECT;
            end
            default: begin
                state_d = COLLECT;
                k_d     = 2'd0;
                lsb_d   = 8'h00;
                last_d  = 1'b0;
            end
        endcase

        if (wr_d && final_s) begin
            wc_d    = count_q + WC_ONE;
            wcv_d   = 1'b1;
            count_d = {WC_WIDTH{1'b0}};
        end else if (wr_d) begin
            count_d = count_q + WC_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // State and output registers.
    always_ff @(posedge WrClock or posedge Reset) begin
        if (Reset) begin
            state_q    <= COLLECT;
            k_q        <= 2'd0;
            lsb_q      <= 8'h00;
            last_q     <= 1'b0;
            data_q     <= 8'h00;
            wr_q       <= 1'b0;
            count_q    <= {WC_WIDTH{1'b0}};
            wc_q       <= {WC_WIDTH{1'b0}};
            wcv_q      <= 1'b0;
            partial_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            lsb_q      <= lsb_d;
            last_q     <= last_d;
            data_q     <= data_d;
            wr_q       <= wr_d;
            count_q    <= count_d;
            wc_q       <= wc_d;
            wcv_q      <= wcv_d;
            partial_q  <= partial_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_pixel2byte_packer.sv
// Directed bench for pixel2byte_packer: one instance each of RAW8, RAW10 and RAW12.
module tb_pixel2byte_packer;

    logic clk;
    logic rst;
    logic af;
    logic full;

    logic [7:0]  d8;  logic v8,  l8,  r8,  fw8,  wcv8,  ep8,  eo8;  logic [7:0] fd8;  logic [15:0] wc8;
    logic [9:0]  d10; logic v10, l10, r10, fw10, wcv10, ep10, eo10; logic [7:0] fd10; logic [15:0] wc10;
    logic [11:0] d12; logic v12, l12, r12, fw12, wcv12, ep12, eo12; logic [7:0] fd12; logic [15:0] wc12;

    int n_checks;
    int n_errors;

    pixel2byte_packer #(.PIX_BITS(8), .WC_WIDTH(16)) u8 (
        .WrClock(clk), .Reset(rst), .pix_data(d8), .pix_valid(v8), .pix_last(l8),
        .pix_ready(r8), .fifo_Data(fd8), .fifo_WrEn(fw8), .fifo_AlmostFull(af),
        .fifo_Full(full), .line_wc(wc8), .line_wc_valid(wcv8), .err_partial(ep8),
        .err_overflow(eo8)
    );

    pixel2byte_packer #(.PIX_BITS(10), .WC_WIDTH(16)) u10 (
        .WrClock(clk), .Reset(rst), .pix_data(d10), .pix_valid(v10), .pix_last(l10),
        .pix_ready(r10), .fifo_Data(fd10), .fifo_WrEn(fw10), .fifo_AlmostFull(af),
        .fifo_Full(full), .line_wc(wc10), .line_wc_valid(wcv10), .err_partial(ep10),
        .err_overflow(eo10)
    );

    pixel2byte_packer #(.PIX_BITS(12), .WC_WIDTH(16)) u12 (
        .WrClock(clk), .Reset(rst), .pix_data(d12), .pix_valid(v12), .pix_last(l12),
        .pix_ready(r12), .fifo_Data(fd12), .fifo_WrEn(fw12), .fifo_AlmostFull(af),
        .fifo_Full(full), .line_wc(wc12), .line_wc_valid(wcv12), .err_partial(ep12),
        .err_overflow(eo12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push8(input logic [7:0] d, input logic last, input logic [7:0] exp_b,
                         input logic exp_wcv);
        d8 = d; v8 = 1'b1; l8 = last;
        #1 chk("raw8 ready", {31'd0, r8}, 32'd1);
        tick();
        chk("raw8 byte", {24'd0, fd8}, {24'd0, exp_b});
        chk("raw8 wren", {31'd0, fw8}, 32'd1);
        chk("raw8 wc_valid", {31'd0, wcv8}, {31'd0, exp_wcv});
        v8 = 1'b0; l8 = 1'b0;
    endtask

    task automatic push10(input logic [9:0] d, input logic last, input logic [7:0] exp_b);
        d10 = d; v10 = 1'b1; l10 = last;
        #1 chk("raw10 ready", {31'd0, r10}, 32'd1);
        tick();
        chk("raw10 msb byte", {24'd0, fd10}, {24'd0, exp_b});
        chk("raw10 msb wren", {31'd0, fw10}, 32'd1);
        chk("raw10 msb wc_valid", {31'd0, wcv10}, 32'd0);
        v10 = 1'b0; l10 = 1'b0;
    endtask

    task automatic emit10(input logic [7:0] exp_b, input logic fin, input logic [15:0] exp_wc);
        #1 chk("raw10 ready in emit", {31'd0, r10}, 32'd0);
        tick();
        chk("raw10 lsb byte", {24'd0, fd10}, {24'd0, exp_b});
        chk("raw10 lsb wren", {31'd0, fw10}, 32'd1);
        chk("raw10 lsb wc_valid", {31'd0, wcv10}, {31'd0, fin});
        if (fin) chk("raw10 line_wc", {16'd0, wc10}, {16'd0, exp_wc});
    endtask

    task automatic push12(input logic [11:0] d, input logic last, input logic [7:0] exp_b);
        d12 = d; v12 = 1'b1; l12 = last;
        #1 chk("raw12 ready", {31'd0, r12}, 32'd1);
        tick();
        chk("raw12 msb byte", {24'd0, fd12}, {24'd0, exp_b});
        chk("raw12 msb wren", {31'd0, fw12}, 32'd1);
        v12 = 1'b0; l12 = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst = 1'b1; af = 1'b0; full = 1'b0;
        d8 = 8'h00;   v8 = 1'b0;  l8 = 1'b0;
        d10 = 10'h000; v10 = 1'b0; l10 = 1'b0;
        d12 = 12'h000; v12 = 1'b0; l12 = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset data", {24'd0, fd10}, 32'd0);
        chk("reset wren", {31'd0, fw10}, 32'd0);
        chk("reset line_wc", {16'd0, wc10}, 32'd0);
        chk("reset wc_valid", {31'd0, wcv10}, 32'd0);
        chk("reset err_partial", {31'd0, ep10}, 32'd0);
        chk("reset err_overflow", {31'd0, eo10}, 32'd0);
        chk("reset ready", {31'd0, r10}, 32'd1);
        rst = 1'b0;
        tick();

        // RAW8 line 11,22,33
        push8(8'h11, 1'b0, 8'h11, 1'b0);
        push8(8'h22, 1'b0, 8'h22, 1'b0);
        push8(8'h33, 1'b1, 8'h33, 1'b1);
        chk("raw8 line_wc", {16'd0, wc8}, 32'd3);
        l8 = 1'b1;
        tick();
        chk("raw8 idle wren", {31'd0, fw8}, 32'd0);
        chk("raw8 idle wc_valid", {31'd0, wcv8}, 32'd0);
        chk("raw8 data hold", {24'd0, fd8}, 32'h33);
        l8 = 1'b0;

        // RAW10 full group
        push10(10'h3FF, 1'b0, 8'hFF);
        push10(10'h000, 1'b0, 8'h00);
        push10(10'h155, 1'b0, 8'h55);
        push10(10'h2AA, 1'b1, 8'hAA);
        emit10(8'h93, 1'b1, 16'd5);
        #1 chk("raw10 ready after emit", {31'd0, r10}, 32'd1);
        chk("raw10 no partial", {31'd0, ep10}, 32'd0);

        // RAW12 line
        push12(12'hABC, 1'b0, 8'hAB);
        push12(12'h123, 1'b1, 8'h12);
        #1 chk("raw12 ready in emit", {31'd0, r12}, 32'd0);
        tick();
        chk("raw12 lsb byte", {24'd0, fd12}, 32'h3C);
        chk("raw12 lsb wren", {31'd0, fw12}, 32'd1);
        chk("raw12 wc_valid", {31'd0, wcv12}, 32'd1);
        chk("raw12 line_wc", {16'd0, wc12}, 32'd3);

        // RAW10 partial 6-pixel line
        push10(10'h3FF, 1'b0, 8'hFF);
        push10(10'h000, 1'b0, 8'h00);
        push10(10'h155, 1'b0, 8'h55);
        push10(10'h2AA, 1'b0, 8'hAA);
        emit10(8'h93, 1'b0, 16'd0);
        push10(10'h3FF, 1'b0, 8'hFF);
        chk("partial flag before", {31'd0, ep10}, 32'd0);
        push10(10'h2AA, 1'b1, 8'hAA);
        chk("partial flag set", {31'd0, ep10}, 32'd1);
        emit10(8'h0B, 1'b1, 16'd8);

        // Backpressure: AlmostFull during the LSB cycle and after
        push10(10'h001, 1'b0, 8'h00);
        push10(10'h002, 1'b0, 8'h00);
        push10(10'h003, 1'b0, 8'h00);
        push10(10'h004, 1'b1, 8'h01);
        af = 1'b1;
        emit10(8'h39, 1'b1, 16'd5);
        d10 = 10'h3FF; v10 = 1'b1; l10 = 1'b1;
        #1 chk("bp ready low", {31'd0, r10}, 32'd0);
        tick();
        chk("bp no write 1", {31'd0, fw10}, 32'd0);
        chk("bp data hold", {24'd0, fd10}, 32'h39);
        tick();
        chk("bp no write 2", {31'd0, fw10}, 32'd0);
        af = 1'b0;
        #1 chk("bp ready back", {31'd0, r10}, 32'd1);
        tick();
        chk("bp resumed byte", {24'd0, fd10}, 32'hFF);
        chk("bp resumed wren", {31'd0, fw10}, 32'd1);
        v10 = 1'b0; l10 = 1'b0;
        emit10(8'h03, 1'b1, 16'd2);

        // Reset mid-group
        push10(10'h3FF, 1'b0, 8'hFF);
        push10(10'h155, 1'b0, 8'h55);
        #2 rst = 1'b1;
        #1;
        chk("midrst data", {24'd0, fd10}, 32'd0);
        chk("midrst wren", {31'd0, fw10}, 32'd0);
        chk("midrst line_wc", {16'd0, wc10}, 32'd0);
        chk("midrst err_partial", {31'd0, ep10}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("postrst idle wren", {31'd0, fw10}, 32'd0);
        push10(10'h2AA, 1'b0, 8'hAA);
        push10(10'h155, 1'b1, 8'h55);
        emit10(8'h06, 1'b1, 16'd3);
        chk("postrst partial", {31'd0, ep10}, 32'd1);

        // Overflow: write presented while Full
        full = 1'b1;
        push8(8'h44, 1'b0, 8'h44, 1'b0);
        chk("overflow before", {31'd0, eo8}, 32'd0);
        tick();
        chk("overflow set", {31'd0, eo8}, 32'd1);
        full = 1'b0;
        tick();
        chk("overflow sticky", {31'd0, eo8}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
